// File: rtl/rs_pkg.sv
// Shared types and default widths for the reservation-station issue scheduler.
package rs_pkg;

    localparam int TAG_WIDTH    = 8;
    localparam int ALU_OP_WIDTH = 7;
    localparam int BIT_WIDTH    = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } issue_state_e;

endpackage

// File: rtl/rs_grant_arbiter.sv
// Picks one requesting slot: round-robin from ptr_i by default, or oldest-first
// from an age matrix when RS_OLDEST_FIRST_EN is defined.
module rs_grant_arbiter #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0]           req_i,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [NUM_SLOTS*NUM_SLOTS-1:0] age_i,
`else
    input  logic [IDX_W-1:0]               ptr_i,
`endif
    output logic [NUM_SLOTS-1:0]           grant_o,
    output logic [IDX_W-1:0]               grant_idx_o,
    output logic                           grant_any_o
);

`ifdef RS_OLDEST_FIRST_EN
    // age_i[j*NUM_SLOTS+i] set means slot j was allocated before slot i.
    logic [NUM_SLOTS-1:0] cand;
    logic [NUM_SLOTS-1:0] older;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        cand        = '0;
        older       = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                older[j] = age_i[j*NUM_SLOTS + i];
            end
            cand[i] = req_i[i] & ~|(req_i & older);
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!grant_any_o && cand[i]) begin
                grant_any_o = 1'b1;
                grant_idx_o = IDX_W'(i);
            end
        end
        grant_o = grant_any_o ? (NUM_SLOTS'(1) << grant_idx_o) : '0;
    end
`else
    logic [IDX_W-1:0] idx;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        idx         = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = ptr_i + IDX_W'(k);
            if (!grant_any_o && req_i[idx]) begin
                grant_any_o = 1'b1;
                grant_idx_o = idx;
            end
        end
        grant_o = grant_any_o ? (NUM_SLOTS'(1) << grant_idx_o) : '0;
    end
`endif

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station allocation and single-issue scheduler.
// Define RS_OLDEST_FIRST_EN for oldest-first issue instead of round-robin.
module rs_issue_scheduler
    import rs_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int TAG_WIDTH    = rs_pkg::TAG_WIDTH,
    parameter int ALU_OP_WIDTH = rs_pkg::ALU_OP_WIDTH,
    parameter int BIT_WIDTH    = rs_pkg::BIT_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              dispValid,
    output logic                              dispReady,
    output logic [NUM_SLOTS-1:0]              slotWr,
    input  logic [NUM_SLOTS-1:0]              slotBusy,
    input  logic [NUM_SLOTS-1:0]              slotReady,
    input  logic [NUM_SLOTS*TAG_WIDTH-1:0]    slotTag,
    input  logic [NUM_SLOTS*ALU_OP_WIDTH-1:0] slotOp,
    input  logic [NUM_SLOTS*BIT_WIDTH-1:0]    slotVj,
    input  logic [NUM_SLOTS*BIT_WIDTH-1:0]    slotVk,
    output logic [NUM_SLOTS-1:0]              slotInstrRecieved,
    output logic                              fuValid,
    input  logic                              fuReady,
    output logic [TAG_WIDTH-1:0]              fuTag,
    output logic [ALU_OP_WIDTH-1:0]           fuOp,
    output logic [BIT_WIDTH-1:0]              fuVj,
    output logic [BIT_WIDTH-1:0]              fuVk
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    issue_state_e             state_q, state_d;
    logic [NUM_SLOTS-1:0]     issued_q, issued_d;
    logic [IDX_W-1:0]         held_idx_q, held_idx_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [ALU_OP_WIDTH-1:0]  op_q, op_d;
    logic [BIT_WIDTH-1:0]     vj_q, vj_d;
    logic [BIT_WIDTH-1:0]     vk_q, vk_d;

    logic [NUM_SLOTS-1:0]     free, alloc_oh, held_mask, eligible, grant_oh;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_any, handshake, load;
    logic [TAG_WIDTH-1:0]     sel_tag;
    logic [ALU_OP_WIDTH-1:0]  sel_op;
    logic [BIT_WIDTH-1:0]     sel_vj, sel_vk;

    // A slot released this cycle only becomes free after issued_q captures it.
    assign free      = ~slotBusy | issued_q;
    assign alloc_oh  = free & (~free + NUM_SLOTS'(1));
    assign dispReady = |free;
    assign slotWr    = (dispValid && dispReady && !reset) ? alloc_oh : '0;

    assign held_mask = (state_q == ST_HOLD) ? (NUM_SLOTS'(1) << held_idx_q) : '0;
    assign eligible  = slotBusy & slotReady & ~issued_q & ~held_mask;
    assign handshake = (state_q == ST_HOLD) && fuReady && !reset;
    assign load      = (state_q == ST_IDLE) || handshake;

    assign slotInstrRecieved = handshake ? held_mask : '0;

    assign fuValid = (state_q == ST_HOLD);
    assign fuTag   = tag_q;
    assign fuOp    = op_q;
    assign fuVj    = vj_q;
    assign fuVk    = vk_q;

    always_comb begin
        sel_tag = '0;
        sel_op  = '0;
        sel_vj  = '0;
        sel_vk  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sel_tag |= slotTag[i*TAG_WIDTH +: TAG_WIDTH]       & {TAG_WIDTH{grant_oh[i]}};
            sel_op  |= slotOp[i*ALU_OP_WIDTH +: ALU_OP_WIDTH]  & {ALU_OP_WIDTH{grant_oh[i]}};
            sel_vj  |= slotVj[i*BIT_WIDTH +: BIT_WIDTH]        & {BIT_WIDTH{grant_oh[i]}};
            sel_vk  |= slotVk[i*BIT_WIDTH +: BIT_WIDTH]        & {BIT_WIDTH{grant_oh[i]}};
        end
    end

    always_comb begin
        state_d    = state_q;
        held_idx_d = held_idx_q;
        tag_d      = tag_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        issued_d   = (issued_q & ~slotWr) | (handshake ? held_mask : '0);
        if (load) begin
            if (grant_any) begin
                state_d    = ST_HOLD;
                held_idx_d = grant_idx;
                tag_d      = sel_tag;
                op_d       = sel_op;
                vj_d       = sel_vj;
                vk_d       = sel_vk;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            held_idx_q <= '0;
            tag_q      <= '0;
            op_q       <= '0;
            vj_q       <= '0;
            vk_q       <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            held_idx_q <= held_idx_d;
            tag_q      <= tag_d;
            op_q       <= op_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // age_q[i*NUM_SLOTS+j] set means slot i was allocated before slot j.
    logic [NUM_SLOTS*NUM_SLOTS-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (slotWr[i]) begin
                    age_d[i*NUM_SLOTS + j] = 1'b0;
                end else if (slotWr[j] && (i != j)) begin
                    age_d[i*NUM_SLOTS + j] = 1'b1;
                end
            end
        end
    end

    // NOTE: the age matrix is small and decides grant order, so it is reset rather than left unknown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    rs_grant_arbiter #(
        .NUM_SLOTS   (NUM_SLOTS),
        .IDX_W       (IDX_W)
    ) u_grant_arbiter (
        .req_i       (eligible),
        .age_i       (age_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr_d = (load && grant_any) ? grant_idx + IDX_W'(1) : rr_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    rs_grant_arbiter #(
        .NUM_SLOTS   (NUM_SLOTS),
        .IDX_W       (IDX_W)
    ) u_grant_arbiter (
        .req_i       (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );
`endif

endmodule
